// File: rtl/crc_param_serial.sv
`default_nettype none
// ============================================================================
// crc_param_serial : bit-serial reflected CRC engine. It accumulates while
//                    active_i is high, then shifts out WIDTH CRC bits LSB first.
//                    Optional macro: CRC_FINAL_XOR_EN applies FINAL_XOR to the output.
// Revision         : 1.0
// ============================================================================
module crc_param_serial #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'('hC4),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'('hD8),
    parameter logic [WIDTH-1:0] FINAL_XOR = WIDTH'('hFF)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic init_i,
    input  logic active_i,
    input  logic data_i,
    output logic crc_o,
    output logic valid_o,
    output logic busy_o
);

    localparam int unsigned       CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     c_CNT_LAST = CW'(WIDTH);
`ifdef CRC_FINAL_XOR_EN
    localparam logic [WIDTH-1:0]  c_OUT_MASK = FINAL_XOR;
`else
    localparam logic [WIDTH-1:0]  c_OUT_MASK = FINAL_XOR & {WIDTH{1'b0}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             crc_q,   crc_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load;

    assign w_step = (lfsr_q >> 1) ^ ((lfsr_q[0] ^ data_i) ? POLY : {WIDTH{1'b0}});
    // The output mask is folded into the register once, as serialisation begins;
    // after that the register is only shifted, so bit k leaves XORed with mask bit k.
    assign w_load = lfsr_q ^ c_OUT_MASK;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        crc_d   = 1'b0;
        valid_d = 1'b0;
        if (init_i) begin
            state_d = S_IDLE;
            lfsr_d  = SEED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (active_i) begin
                        lfsr_d  = w_step;
                        state_d = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (active_i) begin
                        lfsr_d = w_step;
                    end else begin
                        crc_d   = w_load[0];
                        valid_d = 1'b1;
                        lfsr_d  = w_load >> 1;
                        cnt_d   = CW'(1);
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    if (cnt_q < c_CNT_LAST) begin
                        crc_d   = lfsr_q[0];
                        valid_d = 1'b1;
                        lfsr_d  = lfsr_q >> 1;
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        lfsr_d  = SEED;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            crc_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign crc_o   = crc_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule
`default_nettype wire

// File: doc/crc_param_serial.md
CRC_PARAM_SERIAL -- requirements
Module: crc_param_serial

Interface
REQ-001 Parameter WIDTH, default 8, CRC register width in bits; legal range 2..32.
REQ-002 Parameter POLY, default 'hC4, WIDTH-bit tap mask, right-shift (reflected) form; bit i set means feedback XORs into LFSR bit i.
REQ-003 Parameter SEED, default 'hD8, WIDTH-bit LFSR value loaded at reset, INIT and frame end.
REQ-004 Parameter FINAL_XOR, default 'hFF, WIDTH-bit output mask, used only when CRC_FINAL_XOR_EN is defined.
REQ-005 CLK  input  1  single clock; all state updates on the rising edge.
REQ-006 RST  input  1  reset is asynchronous and active-high.
REQ-007 INIT  input  1  synchronous abort and seed reload.
REQ-008 ACTIVE  input  1  DATA qualifier; high means one message bit per cycle.
REQ-009 DATA  input  1  serial message bit.
REQ-010 CRC  output  1  registered serial CRC bit, LSB first.
REQ-011 Valid  output  1  registered; high while CRC carries a checksum bit.
REQ-012 BUSY  output  1  registered; high in ACCUM and OUT.

Function
REQ-013 Internal state: LFSR[WIDTH-1:0], bit counter of $clog2(WIDTH+1) bits, FSM with states IDLE, ACCUM and OUT.
REQ-014 Accumulate step: fb = LFSR[0] ^ DATA; LFSR_next = (LFSR >> 1) ^ (fb ? POLY : 0).
REQ-015 IDLE: ACTIVE=1 performs one accumulate step and moves to ACCUM; ACTIVE=0 holds LFSR, with CRC=0, Valid=0 and BUSY=0.
REQ-016 ACCUM: ACTIVE=1 performs an accumulate step each cycle; ACTIVE=1 may be non-continuous only by leaving ACCUM.
REQ-017 ACCUM with ACTIVE=0 moves to OUT and, at the same edge, registers CRC=LFSR[0], sets Valid=1, shifts LFSR right by one (MSB filled with 0) and sets count=1.
REQ-018 OUT: each edge with count<WIDTH registers CRC=LFSR[0], keeps Valid=1, shifts LFSR and increments count; Valid stays high for exactly WIDTH consecutive cycles.
REQ-019 OUT with count==WIDTH clears Valid and CRC, reloads LFSR=SEED, clears count and moves to IDLE.
REQ-020 ACTIVE is ignored in OUT; data presented there is dropped, and upstream SHALL use BUSY.
REQ-021 A frame starting at the edge that returns to IDLE is not accepted; the first accepted ACTIVE is one cycle after BUSY falls.
REQ-022 No ACTIVE cycle between frames means no output; the seed is never serialised on its own.
REQ-023 A single-bit frame (ACTIVE high for one cycle) is legal and yields a full WIDTH-bit output.
REQ-024 INIT=1 takes priority over ACTIVE in any state: LFSR=SEED, count=0, Valid=0, CRC=0, FSM=IDLE at the next edge.
REQ-025 Latency: the first CRC bit is valid on the first edge after the last ACTIVE cycle; the frame-to-frame gap is at least 1 cycle.

Reset
REQ-026 RST=1 asynchronously forces LFSR=SEED, count=0, FSM=IDLE, CRC=0, Valid=0 and BUSY=0, regardless of CLK.
REQ-027 Reset mid-ACCUM or mid-OUT discards the partial frame; the first ACTIVE after release starts a fresh frame from SEED.

Configuration
REQ-028 Macro CRC_FINAL_XOR_EN: when defined, each serialised bit k (k=0..WIDTH-1) SHALL be LFSR bit XOR FINAL_XOR[k]; when undefined, the output is the raw LFSR bit and FINAL_XOR is unused. LFSR arithmetic is unchanged in both builds.

Verification
REQ-029 Defaults, macro off, reset then ACTIVE=1 DATA=0 for 1 cycle -> CRC bits 0,0,1,1,0,1,1,0 over 8 Valid cycles (0x6C), then BUSY=0.
REQ-030 Defaults, macro off, single bit DATA=1 -> CRC bits 0,0,0,1,0,1,0,1 (0xA8); back-to-back second identical frame -> identical bits (seed reload proven).
REQ-031 Defaults, macro on, single bit DATA=0 -> CRC bits 1,1,0,0,1,0,0,1 (0x93).
REQ-032 RST pulsed asynchronously at the 4th Valid cycle -> Valid=0, CRC=0 immediately; next single DATA=0 frame -> 0x6C sequence.
REQ-033 INIT=1 together with ACTIVE=1 in ACCUM -> next cycle IDLE, BUSY=0, LFSR=SEED; ACTIVE held high during OUT -> output unchanged versus the idle-ACTIVE case.
REQ-034 WIDTH=16, POLY='hA001, SEED='hFFFF, macro off: 8-bit message 0x01 LSB-first -> Valid high for exactly 16 cycles, with bits matching the reference model CRC-16/MODBUS register 0x807E (LSB first).
